kamikaze_imem_responder: RTL and testbench
==========================================

KAMIKAZE_IMEM_RESPONDER -- requirements
Module: kamikaze_imem_responder

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the bus wait-cycle limit before error return (range 1..255).
REQ-002 Parameter ERR_WORD, default 32'h00000000, SHALL set the word returned on bus error or timeout (illegal instruction).
REQ-003 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 fetch_en_i  input  1  SHALL enable new fetch acceptance from the instruction fetcher.
REQ-006 pc_mem_i  input  32  SHALL carry the fetch byte address; bits [1:0] ignored (word aligned).
REQ-007 flush_i  input  1  SHALL carry the branch/flush indication from the fetch side.
REQ-008 ir_o  output  32  SHALL carry the returned instruction word.
REQ-009 memory_ready_o  output  1  SHALL pulse high one cycle per returned word.
REQ-010 err_o  output  1  SHALL flag, with memory_ready_o, that ir_o is ERR_WORD from an error or timeout.
REQ-011 bus_req_o  output  1  SHALL request a read on the backing bus.
REQ-012 bus_addr_o  output  32  SHALL carry the word-aligned bus read address.
REQ-013 bus_ack_i, bus_err_i  input  1 each  SHALL complete a bus read (success/error), honoured only while bus_req_o=1.
REQ-014 bus_rdata_i  input  32  SHALL carry read data, valid in the cycle bus_ack_i=1.

Function
REQ-015 States SHALL be IDLE, HIT, REQ, DRAIN; one-entry tag register (tag_q[29:0], valid_q) SHALL hold the last successfully read word address and data.
REQ-016 IDLE, fetch_en_i=1, flush_i=0: sample addr_q=pc_mem_i[31:2]; if valid_q and tag match -> HIT, else -> REQ.
REQ-017 HIT: next edge SHALL drive ir_o=cached data, memory_ready_o=1, err_o=0, return to IDLE; HIT latency exactly 2 cycles from sample to ready (no bus activity).
REQ-018 REQ: bus_req_o=1, bus_addr_o={addr_q,2'b00} held stable until completion; wait counter SHALL increment each cycle without ack/err.
REQ-019 REQ with bus_ack_i=1: ir_o=bus_rdata_i, memory_ready_o=1 next cycle, tag_q=addr_q, cached data updated, valid_q=1, -> IDLE.
REQ-020 REQ with bus_err_i=1 (wins over bus_ack_i when both high): ir_o=ERR_WORD, err_o=1, memory_ready_o=1, valid_q=0, -> IDLE.
REQ-021 REQ with counter reaching TIMEOUT and no ack/err: bus_req_o drops, same response as REQ-020, -> IDLE; counter cleared on every entry to REQ.
REQ-022 flush_i=1 in IDLE or HIT: no response produced, stay/return IDLE; new sample possible the cycle after flush_i deasserts.
REQ-023 flush_i=1 in REQ: -> DRAIN; DRAIN keeps bus_req_o/bus_addr_o until ack, err, or timeout, then discards data (no memory_ready_o, no tag update) and -> IDLE.
REQ-024 flush_i in the same cycle as bus_ack_i in REQ: response discarded, tag NOT updated, -> IDLE.
REQ-025 memory_ready_o and err_o SHALL be registered, high at most one cycle per accepted fetch; ir_o SHALL hold its last value otherwise.
REQ-026 Throughput: at most one outstanding bus read; back-to-back zero-wait misses yield one word per 3 cycles.

Reset
REQ-027 rst_i=1 SHALL force state=IDLE, valid_q=0, counter=0, bus_req_o=0, bus_addr_o=0, ir_o=32'h00000013 (NOP), memory_ready_o=0, err_o=0, overriding all other inputs including mid-REQ; an in-flight bus read SHALL be abandoned.

Verification
REQ-028 Miss: pc_mem_i=0x100, zero-wait bus returning 0x00A00093 -> bus_addr_o=0x100, 3 cycles later memory_ready_o=1, ir_o=0x00A00093, err_o=0.
REQ-029 Hit: re-present 0x102 after REQ-028 -> no bus_req_o, memory_ready_o=1 after 2 cycles, ir_o=0x00A00093.
REQ-030 Bus error with ack same cycle on 0x200 -> ir_o=0, err_o=1, memory_ready_o=1; re-present 0x200 -> new bus read (no hit).
REQ-031 Timeout: TIMEOUT=4, bus never acks -> bus_req_o high 4 cycles then low, one memory_ready_o with err_o=1.
REQ-032 Flush mid-REQ on 0x300, ack 5 cycles later with 0xDEADBEEF -> bus_req_o held until ack, no memory_ready_o, later fetch of 0x300 misses.
REQ-033 rst_i pulsed while in REQ -> next cycle all outputs at REQ-027 values, ir_o=0x00000013.

Source files
------------

// File: rtl/kamikaze_imem_responder_if.sv
// rtl/kamikaze_imem_responder_if.sv - backing-bus read port for the instruction memory responder
interface kamikaze_imem_responder_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  err,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output err,
        output rdata
    );
endinterface

// File: rtl/kamikaze_imem_responder.sv
// rtl/kamikaze_imem_responder.sv - one-entry cached instruction fetch responder over a single-outstanding read bus
module kamikaze_imem_responder #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_WORD = 32'h00000000
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             fetch_en_i,
    input  logic [31:0]                      pc_mem_i,
    input  logic                             flush_i,
    output logic [31:0]                      ir_o,
    output logic                             memory_ready_o,
    output logic                             err_o,
    kamikaze_imem_responder_if.master        bus
);

    localparam logic [31:0] NOP_WORD = 32'h00000013;
    // Last wait-count value; reaching it without ack/err ends the read as a timeout.
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIT,
        S_REQ,
        S_DRAIN
    } state_t;

    state_t      state_q;
    logic [29:0] addr_q;
    logic [29:0] tag_q;
    logic [31:0] data_q;
    logic        valid_q;
    logic [7:0]  cnt_q;

    logic        hit_w;
    logic        done_w;
    logic        unused_pc_bits;

    // Fetch addresses are word aligned; the byte offset carries no information.
    assign unused_pc_bits = ^pc_mem_i[1:0];

    // Tag lookup against the presented PC, used only when sampling in IDLE.
    assign hit_w  = valid_q && (tag_q == pc_mem_i[31:2]);

    // The read in flight finishes on ack, error, or when the wait budget runs out.
    assign done_w = bus.ack || bus.err || (cnt_q == CNT_LAST);

    // Single FSM: fetch acceptance, bus read sequencing, one-entry cache and registered responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            tag_q          <= '0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            cnt_q          <= '0;
            bus.req        <= 1'b0;
            bus.addr       <= '0;
            ir_o           <= NOP_WORD;
            memory_ready_o <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            memory_ready_o <= 1'b0;
            err_o          <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fetch_en_i && !flush_i) begin
                        addr_q <= pc_mem_i[31:2];
                        if (hit_w) begin
                            state_q <= S_HIT;
                        end else begin
                            state_q  <= S_REQ;
                            bus.req  <= 1'b1;
                            bus.addr <= {pc_mem_i[31:2], 2'b00};
                            cnt_q    <= '0;
                        end
                    end
                end
                S_HIT: begin
                    state_q <= S_IDLE;
                    if (!flush_i) begin
                        ir_o           <= data_q;
                        memory_ready_o <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (done_w) begin
                        state_q <= S_IDLE;
                        bus.req <= 1'b0;
                        // A flush coinciding with completion discards the word entirely.
                        if (!flush_i) begin
                            memory_ready_o <= 1'b1;
                            if (bus.err || !bus.ack) begin
                                ir_o    <= ERR_WORD;
                                err_o   <= 1'b1;
                                valid_q <= 1'b0;
                            end else begin
                                ir_o    <= bus.rdata;
                                tag_q   <= addr_q;
                                data_q  <= bus.rdata;
                                valid_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (flush_i) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Keep the request up until the bus lets go, then drop the result.
                    if (done_w) begin
                        state_q <= S_IDLE;
                        bus.req <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    bus.req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kamikaze_imem_responder.sv
// tb/tb_kamikaze_imem_responder.sv - self-checking bench for kamikaze_imem_responder
module tb_kamikaze_imem_responder;

    localparam int          TO  = 8;
    localparam logic [31:0] ERR = 32'h00000000;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] ir;
    logic        ready;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    logic        m_valid;
    logic [29:0] m_tag;
    logic [31:0] m_data;
    logic [31:0] m_ir;

    kamikaze_imem_responder_if bus_if ();

    kamikaze_imem_responder #(
        .TIMEOUT  (TO),
        .ERR_WORD (ERR)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .fetch_en_i     (fetch_en),
        .pc_mem_i       (pc),
        .flush_i        (flush),
        .ir_o           (ir),
        .memory_ready_o (ready),
        .err_o          (err),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // mode: 0 ack, 1 err, 2 err+ack, 3 bus silent. lat: index of the request cycle that completes.
    task automatic do_fetch(input logic [31:0] fpc, input int lat, input int mode,
                            input int flush_at, input logic [31:0] rdata);
        logic sampled, hit, to, flushed;
        int   last_rc, exp_req, exp_rdy_t, exp_n_rdy;
        logic exp_err;
        logic [31:0] exp_ir;
        int   rc, cur, n_rdy, rdy_t, n_req;
        logic rdy_err, addr_bad;

        sampled   = (flush_at != 0);
        hit       = sampled && m_valid && (m_tag == fpc[31:2]);
        exp_req   = 0;
        exp_rdy_t = -1;
        exp_err   = 1'b0;
        exp_ir    = m_ir;
        if (sampled && hit) begin
            if (flush_at != 1) begin
                exp_rdy_t = 2;
                exp_ir    = m_data;
            end
        end else if (sampled) begin
            to      = (mode == 3) || (lat > TO - 1);
            last_rc = to ? TO - 1 : lat;
            exp_req = last_rc + 1;
            flushed = (flush_at >= 1) && (flush_at <= last_rc + 1);
            if (!flushed) begin
                exp_rdy_t = last_rc + 2;
                if (to || mode != 0) begin
                    exp_err = 1'b1;
                    exp_ir  = ERR;
                    m_valid = 1'b0;
                end else begin
                    exp_ir  = rdata;
                    m_valid = 1'b1;
                    m_tag   = fpc[31:2];
                    m_data  = rdata;
                end
            end
        end
        exp_n_rdy = (exp_rdy_t >= 0) ? 1 : 0;
        m_ir      = exp_ir;

        rc = 0; n_rdy = 0; rdy_t = -1; n_req = 0; rdy_err = 1'b0; addr_bad = 1'b0;
        for (int t = 0; t <= TO + 4; t++) begin
            if (ready === 1'b1) begin
                n_rdy++;
                rdy_t   = t;
                rdy_err = err;
            end
            cur = -1;
            if (bus_if.req === 1'b1) begin
                n_req++;
                if (bus_if.addr !== {fpc[31:2], 2'b00}) addr_bad = 1'b1;
                cur = rc;
                rc++;
            end else begin
                rc = 0;
            end
            fetch_en     = (t == 0);
            pc           = fpc;
            flush        = (t == flush_at);
            bus_if.ack   = (cur == lat) && (mode == 0 || mode == 2);
            bus_if.err   = (cur == lat) && (mode == 1 || mode == 2);
            bus_if.rdata = (cur == lat) ? rdata : $urandom;
            @(posedge clk);
            #1;
        end
        fetch_en   = 1'b0;
        flush      = 1'b0;
        bus_if.ack = 1'b0;
        bus_if.err = 1'b0;

        chk("ready_count", n_rdy, exp_n_rdy);
        chk("ready_cycle", rdy_t, exp_rdy_t);
        chk("err_flag", {31'b0, rdy_err}, {31'b0, exp_err});
        chk("req_cycles", n_req, exp_req);
        chk("addr_stable", {31'b0, addr_bad}, 32'd0);
        chk("ir_word", ir, exp_ir);
    endtask

    initial begin
        int          rmask, rc, cur;
        logic [31:0] last_ir;
        logic [31:0] pool [4];
        int          r, fa;

        pool[0] = 32'h100; pool[1] = 32'h204; pool[2] = 32'h3F8; pool[3] = 32'h7000;
        rst = 1'b1; fetch_en = 1'b0; pc = '0; flush = 1'b0;
        bus_if.ack = 1'b0; bus_if.err = 1'b0; bus_if.rdata = '0;
        m_valid = 1'b0; m_tag = '0; m_data = '0; m_ir = NOP;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, bus_if.req}, 32'd0);
        chk("rst_addr", bus_if.addr, 32'd0);
        chk("rst_ir", ir, NOP);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_fetch(32'h100, 1, 0, -1, 32'h00A00093);      // miss, ready three cycles after sample
        do_fetch(32'h102, 1, 0, -1, 32'h11111111);      // hit, no bus activity
        do_fetch(32'h200, 1, 2, -1, 32'h55AA55AA);      // error wins over ack
        do_fetch(32'h200, 1, 0, -1, 32'h22222222);      // must miss after error
        do_fetch(32'h240, 99, 3, -1, 32'h0);            // timeout
        do_fetch(32'h300, 5, 0, 1, 32'hDEADBEEF);       // flush mid-read, drained
        do_fetch(32'h300, 1, 0, -1, 32'h33333333);      // must miss after drain
        do_fetch(32'h400, 1, 0, 2, 32'h44444444);       // flush with ack, discarded
        do_fetch(32'h400, 0, 0, -1, 32'h45454545);      // must miss, ack on first request cycle
        do_fetch(32'h400, 1, 0, 1, 32'h0);              // flush during hit, no response
        do_fetch(32'h404, 2, 0, 0, 32'h0);              // flush while idle blocks the sample

        // Back-to-back misses with fetch_en held: one word every three cycles.
        rmask = 0; rc = 0; last_ir = '0;
        for (int t = 0; t <= 9; t++) begin
            if (ready === 1'b1) begin
                rmask |= (1 << t);
                last_ir = ir;
            end
            cur = -1;
            if (bus_if.req === 1'b1) begin cur = rc; rc++; end
            else rc = 0;
            fetch_en     = (t <= 8);
            pc           = 32'h1000 + 32'(4 * t);
            bus_if.ack   = (cur == 1);
            bus_if.rdata = (cur == 1) ? dat(bus_if.addr) : 32'h0;
            @(posedge clk);
            #1;
        end
        fetch_en = 1'b0; bus_if.ack = 1'b0;
        chk("b2b_ready_cycles", rmask, (1 << 3) | (1 << 6) | (1 << 9));
        chk("b2b_last_word", last_ir, dat(32'h1018));
        m_valid = 1'b1; m_tag = 30'(32'h1018 >> 2); m_data = dat(32'h1018); m_ir = dat(32'h1018);

        // Reset in the middle of a read.
        fetch_en = 1'b1; pc = 32'h500;
        @(posedge clk); #1;
        fetch_en = 1'b0;
        @(posedge clk); #1;
        chk("midreq_req_up", {31'b0, bus_if.req}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req", {31'b0, bus_if.req}, 32'd0);
        chk("midrst_addr", bus_if.addr, 32'd0);
        chk("midrst_ir", ir, NOP);
        chk("midrst_ready", {31'b0, ready}, 32'd0);
        chk("midrst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        m_valid = 1'b0; m_ir = NOP;
        @(posedge clk); #1;
        do_fetch(32'h1018, 1, 0, -1, 32'h66666666);     // cache was invalidated by reset

        for (int i = 0; i < 150; i++) begin
            r  = int'($urandom % 8);
            fa = (($urandom % 4) == 0) ? int'($urandom_range(0, 9)) : -1;
            do_fetch(pool[$urandom % 4] | 32'($urandom % 4), int'($urandom_range(0, 10)),
                     (r <= 4) ? 0 : r - 4, fa, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
